spike_rate_decoder: RTL
=======================

# spike_rate_decoder

Output-side rate decoder for the LIF spiking network. It counts spikes per channel over a fixed window of enabled cycles, then presents the per-channel counts and the winning (most active) channel on a valid/ready result port. It sits after the network's spike outputs and turns spike trains back into numeric values for readout or host logic. It is the decode counterpart of the current/spike encoding that drives the network.

## Interface
- `N_CH`, default 8: number of spike input channels (≥2).
- `CNT_W`, default 8: width of each per-channel count; counts saturate at 2^CNT_W−1.
- `WIN_LEN`, default 255: window length in enabled cycles (≥2, <2^16).
- `clk` in, 1: clock.
- `rst_n` in, 1: reset, synchronous, active-low.
- `en` in, 1: count enable; low pauses the window counter and all channel counters.
- `spike_in` in, N_CH: one spike bit per channel, sampled each enabled cycle.
- `out_valid` out, 1: result available.
- `out_ready` in, 1: consumer accepts the result.
- `out_counts` out, N_CH*CNT_W: channel i count at `[i*CNT_W +: CNT_W]`.
- `out_winner` out, $clog2(N_CH): index of the maximum count.
- `out_tie` out, 1: the maximum count is shared by two or more channels.
- `overrun` out, 1: sticky flag; a window result was dropped.

## Operation
- The window counter `win_cnt` (16 bits) counts 0..WIN_LEN−1 on enabled cycles and wraps to 0.
- Channel counters: on each enabled cycle, counter i increments when `spike_in[i]`=1 and holds at 2^CNT_W−1 (saturation, no wrap).
- Window end is an enabled cycle with `win_cnt`=WIN_LEN−1. That cycle's spikes are included.
  - The next-state counts (including this cycle) are evaluated.
  - If the output register is free (`out_valid`=0, or `out_valid`&&`out_ready` this cycle), the counts, winner and tie are loaded and `out_valid`=1.
  - Otherwise the result is discarded and `overrun` is set to 1. The held result is unchanged.
  - Channel counters clear to 0 for the next window, regardless of load or drop.
- Winner: the maximum count, with ties resolved to the lowest index. `out_tie`=1 if more than one channel holds the max. An all-zero window gives winner 0, tie 1.
- Handshake:
  - A transfer occurs on a cycle where `out_valid`&&`out_ready`.
  - `out_valid` falls the next cycle unless a window end on the same cycle reloads the output register, in which case it stays 1 with the new data.
  - While `out_valid`=1 and `out_ready`=0, all `out_*` are stable.
- `en`=0: no counting and no window advance. The output handshake still operates.
- `overrun` clears only on reset.

## Timing
- Reset (synchronous, `rst_n`=0 at a clk edge): `win_cnt`, channel counters, `out_counts`, `out_winner`, `out_tie`, `out_valid` and `overrun` all go to 0. This also applies to a reset issued mid-window or while a result is pending; the partial window is discarded.
- Latency: `out_valid` rises at the clk edge that ends the window-end cycle, i.e. the cycle after the last counted spike.
- `out_ready` is not combinationally routed to any output; all outputs are registered.
- With `en` held at 1 and `out_ready` held at 1, `out_valid` is a 1-cycle pulse every WIN_LEN cycles.

## Structure
- Shared package `snn_pkg` holds:
  - the `N_CH`/`CNT_W` defaults, shared with the network;
  - a count-vector typedef;
  - the `WIN_CNT_W`=16 constant.
- Sub-module `spike_argmax`: combinational comparison tree over N_CH counts, outputting index and tie flag. It is instantiated once, on the next-state counts.
- The top level contains the window counter, channel counters, output register/handshake and overrun flag.

## Test plan
All cases use WIN_LEN=16 and CNT_W=8 unless noted.
- **Reset:** hold `rst_n`=0 for 2 cycles, with spikes active → all outputs 0 and no `out_valid` until 16 enabled cycles after release.
- **Basic window:** ch3 spikes every cycle, ch5 every other cycle, `out_ready`=1 → one `out_valid` pulse after 16 cycles with ch3=16, ch5=8, others 0, winner=3, tie=0. The pattern repeats identically for the next window.
- **Saturation/tie:** CNT_W=4, WIN_LEN=20, all channels spike every cycle → all counts=15, winner=0, tie=1, `overrun`=0.
- **Backpressure:** `out_ready`=0 for 40 cycles, ch1 spiking → first result held stable, `overrun`=1 after the second window end, second result dropped. Raising `out_ready` then transfers the first result; the third window's result arrives normally.
- **Enable gap:** the basic pattern with `en`=0 for 5 cycles at window cycle 7 → counts identical to the uninterrupted run and `out_valid` delayed by 5 cycles.
- **Reset mid-operation:** `rst_n`=0 for 1 cycle at window cycle 10 with a result pending → `out_valid`=0, and the next result comes after a full 16 enabled cycles with counts only from after reset.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the LIF spiking network and its readout blocks.
//   N_CH_DEF / CNT_W_DEF : default channel count and per-channel count width
//   WIN_CNT_W            : width of the decode window counter
//   count_vec_t          : packed per-channel count vector at the default sizes
package snn_pkg;

    localparam int unsigned N_CH_DEF  = 8;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned WIN_CNT_W = 16;

    // Channel i occupies [i*CNT_W_DEF +: CNT_W_DEF].
    typedef logic [N_CH_DEF*CNT_W_DEF-1:0] count_vec_t;

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result port of the spike rate decoder (valid/ready).
//   out_valid  : result available (driven by decoder)
//   out_ready  : consumer accepts result (driven by consumer)
//   out_counts : per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   out_winner : index of the highest count (lowest index on ties)
//   out_tie    : highest count is shared by two or more channels
interface spike_rate_decoder_if
    import snn_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    localparam int unsigned IDX_W = $clog2(N_CH);

    logic                    out_valid;
    logic                    out_ready;
    logic [N_CH*CNT_W-1:0]   out_counts;
    logic [IDX_W-1:0]        out_winner;
    logic                    out_tie;

    modport master (
        output out_valid,
        output out_counts,
        output out_winner,
        output out_tie,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_counts,
        input  out_winner,
        input  out_tie,
        output out_ready
    );

endinterface

// File: rtl/spike_rate_decoder_argmax.sv
// spike_argmax: combinational comparison tree over N_CH counts.
//   counts : packed counts, channel i at [i*CNT_W +: CNT_W]
//   winner : index of the maximum count, lowest index wins ties
//   tie    : the maximum is held by more than one channel
module spike_argmax
    import snn_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic [N_CH*CNT_W-1:0]    counts,
    output logic [$clog2(N_CH)-1:0]  winner,
    output logic                     tie
);

    localparam int unsigned IDX_W = $clog2(N_CH);
    localparam int unsigned N_PAD = 1 << IDX_W;

    logic [N_PAD*CNT_W-1:0] counts_pad;
    logic                   node_vld [N_PAD];
    logic [CNT_W-1:0]       node_val [N_PAD];
    logic [IDX_W-1:0]       node_idx [N_PAD];
    logic                   node_tie [N_PAD];

    // Leaves are padded to a power of two; padding nodes are marked invalid
    // so they never win and never create a false tie. Each level reduces
    // pairs in place: node j takes the better of nodes 2j and 2j+1, the
    // lower-index side winning on equality.
    always_comb begin
        logic eq;
        eq = 1'b0;
        counts_pad = '0;
        counts_pad[N_CH*CNT_W-1:0] = counts;
        for (int unsigned i = 0; i < N_PAD; i++) begin
            node_vld[i] = (i < N_CH);
            node_val[i] = counts_pad[i*CNT_W +: CNT_W];
            node_idx[i] = IDX_W'(i);
            node_tie[i] = 1'b0;
        end
        for (int unsigned w = N_PAD / 2; w > 0; w = w / 2) begin
            for (int unsigned j = 0; j < w; j++) begin
                if (node_vld[2*j+1] && (node_val[2*j+1] > node_val[2*j])) begin
                    node_vld[j] = node_vld[2*j+1];
                    node_val[j] = node_val[2*j+1];
                    node_idx[j] = node_idx[2*j+1];
                    node_tie[j] = node_tie[2*j+1];
                end else begin
                    eq = node_vld[2*j+1] && (node_val[2*j+1] == node_val[2*j]);
                    node_vld[j] = node_vld[2*j];
                    node_val[j] = node_val[2*j];
                    node_idx[j] = node_idx[2*j];
                    node_tie[j] = node_tie[2*j] | eq;
                end
            end
        end
        winner = node_idx[0];
        tie    = node_tie[0];
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over a window of WIN_LEN
// enabled cycles and presents counts, winner and tie on a valid/ready port.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : count enable (pauses window and channel counters when low)
//   spike_in   : one spike bit per channel
//   res        : result port (master side of spike_rate_decoder_if)
//   overrun    : sticky, set when a window result had to be dropped
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned N_CH    = N_CH_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned WIN_LEN = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N_CH-1:0]       spike_in,
    spike_rate_decoder_if.master  res,
    output logic                  overrun
);

    localparam int unsigned      IDX_W    = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(WIN_LEN - 1);

    logic [WIN_CNT_W-1:0]   win_cnt;
    logic [CNT_W-1:0]       cnt_q [N_CH];
    logic [N_CH*CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]       win_idx;
    logic                   win_tie;
    logic                   win_end;
    logic                   out_free;
    logic                   load;

    // Next-state counts include the current cycle's spikes, so the window-end
    // cycle is counted in the result it produces.
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (en && spike_in[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_next[i*CNT_W +: CNT_W] = cnt_q[i] + 1'b1;
            end else begin
                cnt_next[i*CNT_W +: CNT_W] = cnt_q[i];
            end
        end
    end

    assign win_end  = en && (win_cnt == WIN_LAST);
    assign out_free = !res.out_valid || res.out_ready;
    assign load     = win_end && out_free;

    spike_argmax #(
        .N_CH  (N_CH),
        .CNT_W (CNT_W)
    ) u_argmax (
        .counts (cnt_next),
        .winner (win_idx),
        .tie    (win_tie)
    );

    // Window and channel counters; channels clear at window end whether the
    // result was loaded or dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (en) begin
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i] <= win_end ? '0 : cnt_next[i*CNT_W +: CNT_W];
            end
        end
    end

    // Output register and handshake. A reload on the transfer cycle keeps
    // out_valid high with the new result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res.out_valid  <= 1'b0;
            res.out_counts <= '0;
            res.out_winner <= '0;
            res.out_tie    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (load) begin
                res.out_valid  <= 1'b1;
                res.out_counts <= cnt_next;
                res.out_winner <= win_idx;
                res.out_tie    <= win_tie;
            end else if (res.out_ready) begin
                res.out_valid  <= 1'b0;
            end
            if (win_end && !out_free) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule
